// File: rtl/sw_window_3x3_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the 3x3 sliding-window builder:
//   - DATA_W_DEF : default pixel width expected by the bilateral filter
//   - sw_state_e : window FSM states (FILL while fewer than two rows buffered)
//   - col_w/row_w: counter widths derived from the image geometry
// Optional feature macro used by the block: SW_FRAME_SYNC_EN.
// -----------------------------------------------------------------------------
package sw_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } sw_state_e;

  // Width of a column counter / line-buffer pointer for a given line length.
  function automatic int col_w(input int img_width);
    return (img_width > 1) ? $clog2(img_width) : 1;
  endfunction

  // Width of a row counter for a given frame height.
  function automatic int row_w(input int img_height);
    return (img_height > 1) ? $clog2(img_height) : 1;
  endfunction

endpackage

// File: rtl/sw_window_3x3_if.sv
// -----------------------------------------------------------------------------
// sw_window_3x3_if
// Pixel stream in / 3x3 window out bundle of the sliding-window builder.
//   en, pixel_in          : raster-order pixel stream, no backpressure
//   act                   : window valid strobe
//   sw_pixels1..9         : taps, 1..3 top row L->R, 4..6 middle, 7..9 bottom
//   sof, eof              : frame sync (only with SW_FRAME_SYNC_EN defined)
// Modports: master = pixel source / window sink, slave = window builder.
// -----------------------------------------------------------------------------
interface sw_window_3x3_if
  import sw_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              en;
  logic [DATA_W-1:0] pixel_in;
  logic              act;
  logic [DATA_W-1:0] sw_pixels1;
  logic [DATA_W-1:0] sw_pixels2;
  logic [DATA_W-1:0] sw_pixels3;
  logic [DATA_W-1:0] sw_pixels4;
  logic [DATA_W-1:0] sw_pixels5;
  logic [DATA_W-1:0] sw_pixels6;
  logic [DATA_W-1:0] sw_pixels7;
  logic [DATA_W-1:0] sw_pixels8;
  logic [DATA_W-1:0] sw_pixels9;

`ifdef SW_FRAME_SYNC_EN
  logic              sof;
  logic              eof;

  modport master (
    output en, pixel_in, sof,
    input  act, eof,
    input  sw_pixels1, sw_pixels2, sw_pixels3,
    input  sw_pixels4, sw_pixels5, sw_pixels6,
    input  sw_pixels7, sw_pixels8, sw_pixels9
  );

  modport slave (
    input  en, pixel_in, sof,
    output act, eof,
    output sw_pixels1, sw_pixels2, sw_pixels3,
    output sw_pixels4, sw_pixels5, sw_pixels6,
    output sw_pixels7, sw_pixels8, sw_pixels9
  );
`else
  modport master (
    output en, pixel_in,
    input  act,
    input  sw_pixels1, sw_pixels2, sw_pixels3,
    input  sw_pixels4, sw_pixels5, sw_pixels6,
    input  sw_pixels7, sw_pixels8, sw_pixels9
  );

  modport slave (
    input  en, pixel_in,
    output act,
    output sw_pixels1, sw_pixels2, sw_pixels3,
    output sw_pixels4, sw_pixels5, sw_pixels6,
    output sw_pixels7, sw_pixels8, sw_pixels9
  );
`endif

endinterface

// File: rtl/sw_window_3x3_line_buffer.sv
// -----------------------------------------------------------------------------
// sw_line_buffer
// One image line of delay: circular buffer of DEPTH words, DATA_W wide.
// The word at addr is read combinationally before being overwritten on en,
// so rd_data is the pixel written exactly DEPTH accepted pixels earlier.
// Contents are intentionally not reset; the window logic never exposes them
// before two fresh rows have been written.
//   clk     : rising-edge clock
//   en      : write strobe (pixel accepted)
//   addr    : shared line pointer
//   wr_data : word to store
//   rd_data : word previously stored at addr
// -----------------------------------------------------------------------------
module sw_line_buffer
  import sw_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Line storage write port; pure delay, no reset of the array.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sw_window_3x3.sv
// -----------------------------------------------------------------------------
// sw_window_3x3
// Builds the 3x3 sliding window for the bilateral filter from a raster-order
// pixel stream. Two line buffers supply rows r-1 and r-2; a 3x3 register
// window shifts left on every accepted pixel. act rises one cycle after an
// accepted pixel at (row>=2, col>=2), and the taps then hold the window
// centred on (row-1, col-1). Border-centred windows are never emitted.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : sw_window_3x3_if.slave (en, pixel_in -> act, sw_pixels1..9)
// Optional SW_FRAME_SYNC_EN adds bus.sof (forces the accepted pixel to (0,0))
// and bus.eof (pulses with the last window of the frame).
// -----------------------------------------------------------------------------
module sw_window_3x3
  import sw_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  sw_window_3x3_if.slave   bus
);

  localparam int COL_W = col_w(IMG_WIDTH);
  localparam int ROW_W = row_w(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  sw_state_e         state_r, state_s, cur_state_s;
  logic [COL_W-1:0]  col_r, col_s, cur_col_s;
  logic [ROW_W-1:0]  row_r, row_s, cur_row_s;
  logic [COL_W-1:0]  ptr_r, ptr_s;
  logic              act_r, act_s;
  logic              last_s;
  logic              accept_s;
  logic              sof_s;
  logic [DATA_W-1:0] lb0_out_s;
  logic [DATA_W-1:0] lb1_out_s;
  logic [DATA_W-1:0] win_r [3][3];

  assign accept_s = bus.en;

`ifdef SW_FRAME_SYNC_EN
  assign sof_s = bus.en & bus.sof;
`else
  assign sof_s = 1'b0;
`endif

  // Position and state of the pixel being accepted; sof retags it as (0,0).
  always_comb begin
    cur_col_s   = col_r;
    cur_row_s   = row_r;
    cur_state_s = state_r;
    if (sof_s) begin
      cur_col_s   = COL_ZERO;
      cur_row_s   = ROW_ZERO;
      cur_state_s = FILL;
    end else begin
      cur_col_s   = col_r;
      cur_row_s   = row_r;
      cur_state_s = state_r;
    end
  end

  assign last_s = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);

  // Next-state, counter and strobe logic for the fill/run FSM.
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    row_s   = row_r;
    ptr_s   = ptr_r;
    act_s   = 1'b0;
    if (accept_s) begin
      // RUN means rows r-1 and r-2 are valid; col gate hides stale columns.
      act_s = (cur_state_s == RUN) && (cur_col_s >= COL_TWO);
      ptr_s = (ptr_r == COL_LAST) ? COL_ZERO : (ptr_r + COL_ONE);
      if (cur_col_s == COL_LAST) begin
        col_s = COL_ZERO;
        row_s = (cur_row_s == ROW_LAST) ? ROW_ZERO : (cur_row_s + ROW_ONE);
      end else begin
        col_s = cur_col_s + COL_ONE;
        row_s = cur_row_s;
      end
      case (cur_state_s)
        FILL: begin
          if ((cur_row_s == ROW_ONE) && (cur_col_s == COL_LAST)) begin
            state_s = RUN;
          end else begin
            state_s = FILL;
          end
        end
        RUN: begin
          if (last_s) begin
            state_s = FILL;
          end else begin
            state_s = RUN;
          end
        end
        default: state_s = FILL;
      endcase
    end else begin
      state_s = state_r;
      col_s   = col_r;
      row_s   = row_r;
      ptr_s   = ptr_r;
      act_s   = 1'b0;
    end
  end

  // FSM, counters, line pointer and act strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
      col_r   <= COL_ZERO;
      row_r   <= ROW_ZERO;
      ptr_r   <= COL_ZERO;
      act_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
      ptr_r   <= ptr_s;
      act_r   <= act_s;
    end
  end

  // lb0 delays the stream by one line, lb1 delays lb0's output by another.
  sw_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk     (clk),
    .en      (accept_s),
    .addr    (ptr_r),
    .wr_data (bus.pixel_in),
    .rd_data (lb0_out_s)
  );

  sw_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .en      (accept_s),
    .addr    (ptr_r),
    .wr_data (lb0_out_s),
    .rd_data (lb1_out_s)
  );

  // 3x3 window: shift left, new right column = {row-2, row-1, current}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= {DATA_W{1'b0}};
        end
      end
    end else if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        win_r[i][0] <= win_r[i][1];
        win_r[i][1] <= win_r[i][2];
      end
      win_r[0][2] <= lb1_out_s;
      win_r[1][2] <= lb0_out_s;
      win_r[2][2] <= bus.pixel_in;
    end
  end

  assign bus.act        = act_r;
  assign bus.sw_pixels1 = win_r[0][0];
  assign bus.sw_pixels2 = win_r[0][1];
  assign bus.sw_pixels3 = win_r[0][2];
  assign bus.sw_pixels4 = win_r[1][0];
  assign bus.sw_pixels5 = win_r[1][1];
  assign bus.sw_pixels6 = win_r[1][2];
  assign bus.sw_pixels7 = win_r[2][0];
  assign bus.sw_pixels8 = win_r[2][1];
  assign bus.sw_pixels9 = win_r[2][2];

`ifdef SW_FRAME_SYNC_EN
  logic eof_r;

  // End-of-frame strobe, aligned with the last window of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eof_r <= 1'b0;
    end else begin
      eof_r <= accept_s & last_s;
    end
  end

  assign bus.eof = eof_r;
`endif

endmodule

// File: tb/tb_sw_window_3x3.sv
// -----------------------------------------------------------------------------
// tb_sw_window_3x3
// Self-checking bench for sw_window_3x3 with an 8x6 image. A reference model
// stores the accepted frame by (row,col) and derives each expected window
// directly from the image array.
// -----------------------------------------------------------------------------
module tb_sw_window_3x3;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sw_window_3x3_if #(.DATA_W(DW)) bus ();

  sw_window_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [9*DW-1:0] dut_flat;
  assign dut_flat = {bus.sw_pixels1, bus.sw_pixels2, bus.sw_pixels3,
                     bus.sw_pixels4, bus.sw_pixels5, bus.sw_pixels6,
                     bus.sw_pixels7, bus.sw_pixels8, bus.sw_pixels9};

  int checks   = 0;
  int failures = 0;

  // reference model state
  int              m_row, m_col;
  int              img [H][W];
  logic            e_act;
  logic            e_eof;
  logic [9*DW-1:0] e_win;
  logic [9*DW-1:0] gold_q [$];

  // Drive one cycle of stimulus, update the model, sample #1 after the edge.
  task automatic step(input logic e, input logic [7:0] p, input logic s);
    @(negedge clk);
    bus.en       = e;
    bus.pixel_in = p;
`ifdef SW_FRAME_SYNC_EN
    bus.sof      = s;
`endif
    if (e) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      img[m_row][m_col] = int'(p);
      e_act = (m_row >= 2) && (m_col >= 2);
      e_eof = (m_row == H - 1) && (m_col == W - 1);
      if (e_act) begin
        for (int k = 0; k < 9; k++) begin
          e_win[(8 - k) * 8 +: 8] = 8'(img[m_row - 2 + k / 3][m_col - 2 + k % 3]);
        end
      end
      m_col = m_col + 1;
      if (m_col == W) begin
        m_col = 0;
        m_row = (m_row == H - 1) ? 0 : m_row + 1;
      end
    end else begin
      e_act = 1'b0;
      e_eof = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.pixel_in = 8'd0;
`ifdef SW_FRAME_SYNC_EN
    bus.sof      = 1'b0;
`endif
    e_win = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.act !== 1'b0) begin
      failures++;
      $display("FAIL reset_act got=%b exp=0", bus.act);
    end
    checks++;
    if (dut_flat !== 72'd0) begin
      failures++;
      $display("FAIL reset_taps got=%h exp=0", dut_flat);
    end
`ifdef SW_FRAME_SYNC_EN
    checks++;
    if (bus.eof !== 1'b0) begin
      failures++;
      $display("FAIL reset_eof got=%b exp=0", bus.eof);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic test_continuous();
    int first = -1;
    int n_act = 0;
    logic [9*DW-1:0] first_w, last_w;
    logic [7:0] pix;
    first_w = '0;
    last_w  = '0;
    for (int i = 0; i < W * H; i++) begin
      pix = 8'(i);
      step(1'b1, pix, 1'b0);
      checks++;
      if (bus.act !== e_act) begin
        failures++;
        $display("FAIL cont_act i=%0d got=%b exp=%b", i, bus.act, e_act);
      end
      if (e_act) begin
        gold_q.push_back(e_win);
        checks++;
        if (dut_flat !== e_win) begin
          failures++;
          $display("FAIL cont_win i=%0d got=%h exp=%h", i, dut_flat, e_win);
        end
      end
      if (bus.act === 1'b1) begin
        if (first < 0) begin
          first   = i;
          first_w = dut_flat;
        end
        n_act++;
        last_w = dut_flat;
      end
    end
    checks++;
    if (first !== 18) begin
      failures++;
      $display("FAIL cont_first_act got=%0d exp=18", first);
    end
    checks++;
    if ({first_w[71:64], first_w[39:32], first_w[7:0]} !== {8'd0, 8'd9, 8'd18}) begin
      failures++;
      $display("FAIL cont_first_win got=%0d,%0d,%0d exp=0,9,18",
               first_w[71:64], first_w[39:32], first_w[7:0]);
    end
    checks++;
    if ({last_w[39:32], last_w[7:0]} !== {8'd38, 8'd47}) begin
      failures++;
      $display("FAIL cont_last_win got=%0d,%0d exp=38,47", last_w[39:32], last_w[7:0]);
    end
    checks++;
    if (n_act !== 24) begin
      failures++;
      $display("FAIL cont_act_count got=%0d exp=24", n_act);
    end
  endtask

  task automatic test_gaps();
    int idx = 0;
    int wi  = 0;
    int cyc = 0;
    logic e;
    logic [9*DW-1:0] prev_flat;
    logic [7:0] pix;
    while ((idx < W * H) && (cyc < 1000)) begin
      e = ($urandom_range(0, 99) >= 40);
      prev_flat = dut_flat;
      pix = 8'(idx);
      step(e, pix, 1'b0);
      cyc++;
      checks++;
      if (bus.act !== e_act) begin
        failures++;
        $display("FAIL gap_act cyc=%0d got=%b exp=%b", cyc, bus.act, e_act);
      end
      if (!e) begin
        checks++;
        if ((bus.act !== 1'b0) || (dut_flat !== prev_flat)) begin
          failures++;
          $display("FAIL gap_idle_hold cyc=%0d act=%b taps=%h exp act=0 taps=%h",
                   cyc, bus.act, dut_flat, prev_flat);
        end
      end
      if (bus.act === 1'b1) begin
        checks++;
        if ((wi >= gold_q.size()) || (dut_flat !== gold_q[wi])) begin
          failures++;
          $display("FAIL gap_win_seq n=%0d got=%h exp=%h", wi, dut_flat,
                   (wi < gold_q.size()) ? gold_q[wi] : 72'd0);
        end
        wi++;
      end
      if (e) idx++;
    end
    checks++;
    if ((idx !== W * H) || (wi !== 24)) begin
      failures++;
      $display("FAIL gap_totals pixels=%0d windows=%0d exp 48,24", idx, wi);
    end
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    logic [7:0] pix;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        pix = 8'(i + 100 * f);
        step(1'b1, pix, 1'b0);
        checks++;
        if (bus.act !== e_act) begin
          failures++;
          $display("FAIL b2b_act f=%0d i=%0d got=%b exp=%b", f, i, bus.act, e_act);
        end
        if (e_act) begin
          checks++;
          if (dut_flat !== e_win) begin
            failures++;
            $display("FAIL b2b_win f=%0d i=%0d got=%h exp=%h", f, i, dut_flat, e_win);
          end
        end
        if ((f == 1) && (bus.act === 1'b1)) begin
          for (int k = 0; k < 9; k++) begin
            checks++;
            if (dut_flat[k * 8 +: 8] < 8'd100) begin
              failures++;
              $display("FAIL b2b_stale i=%0d byte=%0d got=%0d exp>=100",
                       i, k, dut_flat[k * 8 +: 8]);
            end
          end
          if (!seen) begin
            seen = 1'b1;
            checks++;
            if (bus.sw_pixels5 !== 8'd109) begin
              failures++;
              $display("FAIL b2b_first_centre got=%0d exp=109", bus.sw_pixels5);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    logic [7:0] pix;
    for (int i = 0; i < 30; i++) begin
      pix = 8'($urandom_range(0, 255));
      step(1'b1, pix, 1'b0);
    end
    checks++;
    if (bus.act !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_act got=%b exp=1", bus.act);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ((bus.act !== 1'b0) || (dut_flat !== 72'd0)) begin
      failures++;
      $display("FAIL rst_async_drop act=%b taps=%h exp 0,0", bus.act, dut_flat);
    end
    bus.en       = 1'b1;
    bus.pixel_in = 8'd77;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ((bus.act !== 1'b0) || (dut_flat !== 72'd0)) begin
      failures++;
      $display("FAIL rst_hold act=%b taps=%h exp 0,0", bus.act, dut_flat);
    end
    @(negedge clk);
    bus.en = 1'b0;
    rst_n  = 1'b1;
    m_row  = 0;
    m_col  = 0;
    for (int i = 0; i < W * H; i++) begin
      pix = 8'(i + 50);
      step(1'b1, pix, 1'b0);
      checks++;
      if (bus.act !== e_act) begin
        failures++;
        $display("FAIL rec_act i=%0d got=%b exp=%b", i, bus.act, e_act);
      end
      if (e_act) begin
        checks++;
        if (dut_flat !== e_win) begin
          failures++;
          $display("FAIL rec_win i=%0d got=%h exp=%h", i, dut_flat, e_win);
        end
      end
      if ((bus.act === 1'b1) && (first < 0)) first = i;
    end
    checks++;
    if (first !== 18) begin
      failures++;
      $display("FAIL rec_first_act got=%0d exp=18", first);
    end
  endtask

`ifdef SW_FRAME_SYNC_EN
  task automatic test_sof();
    int first = -1;
    logic [7:0] pix;
    for (int i = 0; i < 25; i++) begin
      pix = 8'($urandom_range(0, 255));
      step(1'b1, pix, 1'b0);
    end
    for (int j = 0; j < W * H; j++) begin
      if (j == 10) begin
        step(1'b0, 8'd0, 1'b1);
        checks++;
        if (bus.act !== 1'b0) begin
          failures++;
          $display("FAIL sof_idle_act got=%b exp=0", bus.act);
        end
      end
      pix = 8'(j + 30);
      step(1'b1, pix, (j == 0));
      checks++;
      if ((bus.act !== e_act) || (bus.eof !== e_eof)) begin
        failures++;
        $display("FAIL sof_act j=%0d got act=%b eof=%b exp act=%b eof=%b",
                 j, bus.act, bus.eof, e_act, e_eof);
      end
      if (e_act) begin
        checks++;
        if (dut_flat !== e_win) begin
          failures++;
          $display("FAIL sof_win j=%0d got=%h exp=%h", j, dut_flat, e_win);
        end
      end
      if ((bus.act === 1'b1) && (first < 0)) first = j;
    end
    checks++;
    if (first !== 18) begin
      failures++;
      $display("FAIL sof_first_act got=%0d exp=18", first);
    end
  endtask

  task automatic test_eof();
    int n_act = 0;
    int n_eof = 0;
    int act_at_eof = -1;
    logic [7:0] pix;
    for (int i = 0; i < W * H; i++) begin
      pix = 8'($urandom_range(0, 255));
      step(1'b1, pix, 1'b0);
      if (bus.act === 1'b1) n_act++;
      checks++;
      if (bus.eof !== e_eof) begin
        failures++;
        $display("FAIL eof_cycle i=%0d got=%b exp=%b", i, bus.eof, e_eof);
      end
      if (bus.eof === 1'b1) begin
        n_eof++;
        act_at_eof = (bus.act === 1'b1) ? n_act : -1;
      end
    end
    checks++;
    if ((n_eof !== 1) || (act_at_eof !== 24)) begin
      failures++;
      $display("FAIL eof_once pulses=%0d act_index=%0d exp 1,24", n_eof, act_at_eof);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
`ifdef SW_FRAME_SYNC_EN
    test_sof();
    test_eof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
